// File: rtl/icache_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : icache_pkg
//  Description : Shared constants for the instruction-cache line-refill
//                engine: default line size, AXI4 burst/response encodings
//                and the refill state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package icache_pkg;

    // Default words per cache line and the matching word-index width
    localparam int ICACHE_LINE_WORDS = 16;
    localparam int ICACHE_WIDX_W     = $clog2(ICACHE_LINE_WORDS);

    // AXI4 encodings
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP = 2'b10;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;

    // Refill state machine encoding
    typedef logic [1:0] refill_state_t;
    localparam refill_state_t ST_IDLE = 2'd0;
    localparam refill_state_t ST_AR   = 2'd1;
    localparam refill_state_t ST_RD   = 2'd2;

endpackage
`default_nettype wire

// File: rtl/icache_refill.sv
`default_nettype none
// ============================================================================
//  Module      : icache_refill
//  Description : Line-refill engine behind the instruction-cache miss path.
//                Captures one refill request, issues a single AXI4 read
//                burst of LINE_WORDS words and streams each returned word to
//                the cache with its line word index. burst pulses with the
//                final word; rerr is a sticky per-refill error flag.
//  Config      : ICACHE_REFILL_CWF_EN - critical word first (WRAP burst from
//                the word-aligned miss address); undefined gives INCR from
//                the line-aligned address with widx starting at 0.
//  Ports       : clk, rst (async, active-low)
//                sen/addr/addr_ok          - cache request handshake
//                sdata/widx/data_ok/burst  - refill word stream to the cache
//                rerr                      - error flag, valid with burst
//                ar*/r*                    - AXI4 AR and R channels
//  Revision    : 1.0 - initial release
// ============================================================================
module icache_refill
    import icache_pkg::*;
#(
    parameter int LINE_WORDS = ICACHE_LINE_WORDS,
    parameter int ADDR_W     = 32,
    parameter int ID_W       = 4,
    parameter int ARID_VAL   = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    // cache request side
    input  logic                          sen,
    input  logic [ADDR_W-1:0]             addr,
    output logic                          addr_ok,
    output logic [31:0]                   sdata,
    output logic [$clog2(LINE_WORDS)-1:0] widx,
    output logic                          data_ok,
    output logic                          burst,
    output logic                          rerr,
    // AXI4 AR channel
    output logic [ID_W-1:0]               arid,
    output logic [ADDR_W-1:0]             araddr,
    output logic [7:0]                    arlen,
    output logic [2:0]                    arsize,
    output logic [1:0]                    arburst,
    output logic                          arvalid,
    input  logic                          arready,
    // AXI4 R channel
    input  logic [ID_W-1:0]               rid,
    input  logic [31:0]                   rdata,
    input  logic [1:0]                    rresp,
    input  logic                          rlast,
    input  logic                          rvalid,
    output logic                          rready
);

    localparam int                WIDX_W     = $clog2(LINE_WORDS);
    localparam int                LINE_SHIFT = WIDX_W + 2;
    localparam logic [WIDX_W-1:0] LAST_CNT   = WIDX_W'(LINE_WORDS - 1);

    refill_state_t        state_q,   state_d;
    logic                 addr_ok_q, addr_ok_d;
    logic                 data_ok_q, data_ok_d;
    logic                 burst_q,   burst_d;
    logic                 rerr_q,    rerr_d;
    logic [31:0]          sdata_q,   sdata_d;
    logic [WIDX_W-1:0]    widx_q,    widx_d;
    logic [ADDR_W-1:0]    araddr_q,  araddr_d;
    logic [WIDX_W-1:0]    cnt_q,     cnt_d;     // words delivered so far
    logic [WIDX_W-1:0]    idx_q,     idx_d;     // widx of the next word
    logic                 pad_q,     pad_d;     // early rlast: emit zero words
    logic                 drain_q,   drain_d;   // missing rlast: sink extra beats

    logic [ADDR_W-1:0]    w_req_araddr;
    logic [WIDX_W-1:0]    w_start_idx;
    logic                 w_emit;
    logic                 w_last;
    logic                 w_unused_sink;

`ifdef ICACHE_REFILL_CWF_EN
    // Critical word first: start at the missing word, slave wraps at the line
    assign w_req_araddr = {addr[ADDR_W-1:2], 2'b00};
    assign w_start_idx  = addr[WIDX_W+1:2];
    assign arburst      = AXI_BURST_WRAP;
`else
    assign w_req_araddr = {addr[ADDR_W-1:LINE_SHIFT], {LINE_SHIFT{1'b0}}};
    assign w_start_idx  = '0;
    assign arburst      = AXI_BURST_INCR;
`endif

    // Only a single outstanding burst, so rid carries no information
    assign w_unused_sink = ^{rid, addr};

    // In padding mode a word is produced every cycle without a bus beat
    assign w_emit = pad_q | rvalid;
    assign w_last = (cnt_q == LAST_CNT);

    always_comb begin
        state_d   = state_q;
        addr_ok_d = 1'b0;
        data_ok_d = 1'b0;
        burst_d   = 1'b0;
        rerr_d    = rerr_q;
        sdata_d   = sdata_q;
        widx_d    = widx_q;
        araddr_d  = araddr_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        pad_d     = pad_q;
        drain_d   = drain_q;

        case (state_q)
            ST_IDLE: begin
                if (drain_q) begin
                    // Hold off new requests until the overlong burst has ended
                    if (rvalid && rlast) begin
                        drain_d = 1'b0;
                    end
                end else if (sen) begin
                    addr_ok_d = 1'b1;
                    rerr_d    = 1'b0;
                    araddr_d  = w_req_araddr;
                    idx_d     = w_start_idx;
                    cnt_d     = '0;
                    pad_d     = 1'b0;
                    state_d   = ST_AR;
                end
            end

            ST_AR: begin
                if (arready) begin
                    state_d = ST_RD;
                end
            end

            ST_RD: begin
                if (w_emit) begin
                    data_ok_d = 1'b1;
                    sdata_d   = pad_q ? 32'd0 : rdata;
                    widx_d    = idx_q;
                    idx_d     = idx_q + 1'b1;
                    cnt_d     = cnt_q + 1'b1;
                    if (!pad_q) begin
                        if (rresp != AXI_RESP_OKAY) begin
                            rerr_d = 1'b1;
                        end
                        if (rlast && !w_last) begin
                            rerr_d = 1'b1;
                            pad_d  = 1'b1;
                        end
                        if (!rlast && w_last) begin
                            rerr_d  = 1'b1;
                            drain_d = 1'b1;
                        end
                    end
                    if (w_last) begin
                        burst_d = 1'b1;
                        pad_d   = 1'b0;
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            addr_ok_q <= 1'b0;
            data_ok_q <= 1'b0;
            burst_q   <= 1'b0;
            rerr_q    <= 1'b0;
            sdata_q   <= 32'd0;
            widx_q    <= '0;
            araddr_q  <= '0;
            cnt_q     <= '0;
            idx_q     <= '0;
            pad_q     <= 1'b0;
            drain_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_ok_q <= addr_ok_d;
            data_ok_q <= data_ok_d;
            burst_q   <= burst_d;
            rerr_q    <= rerr_d;
            sdata_q   <= sdata_d;
            widx_q    <= widx_d;
            araddr_q  <= araddr_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            pad_q     <= pad_d;
            drain_q   <= drain_d;
        end
    end

    assign addr_ok = addr_ok_q;
    assign sdata   = sdata_q;
    assign widx    = widx_q;
    assign data_ok = data_ok_q;
    assign burst   = burst_q;
    assign rerr    = rerr_q;
    assign araddr  = araddr_q;
    assign arvalid = (state_q == ST_AR);
    assign arid    = ID_W'(ARID_VAL);
    assign arlen   = 8'(LINE_WORDS - 1);
    assign arsize  = AXI_SIZE_4B;
    // The cache never back-pressures; also stays high while sinking extra beats
    assign rready  = (state_q == ST_RD) | drain_q;

endmodule
`default_nettype wire
